// File: rtl/mux_pkg.sv
// Shared constants for the N:1 stream mux family.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the channel after the last winner,
// and moves the pointer only when the granted word is actually taken.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] last;
  logic             found;
  int               idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= SEL_W'(N - 1);
    end else if (en) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream multiplexer with a single registered output stage;
// the source is picked either by an external select or by round-robin.
module stream_mux_n_1
  import mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SEL_W = sel_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_valid,
  output logic [N-1:0]       i_ready,
  input  logic [SEL_W-1:0]   s,
  output logic [WIDTH-1:0]   y_data,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [SEL_W-1:0]   y_sel
);

  logic             load;
  logic             xfer;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] mux_data;

  assign load    = ~y_valid | y_ready;
  assign i_ready = gnt & {N{load & ~rst}};
  assign xfer    = |(i_ready & i_valid);

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_s;
      assign unused_s = ^s;

      rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (i_valid),
        .en      (xfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
      );
    end else begin : g_sel
      // Out-of-range select decodes to no grant at all.
      always_comb begin
        gnt     = '0;
        gnt_idx = s;
        for (int k = 0; k < N; k++) begin
          if (int'(s) == k) gnt[k] = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N; k++) begin
      mux_data = mux_data | (i_data[k*WIDTH +: WIDTH] & {WIDTH{gnt[k]}});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_sel   <= '0;
    end else if (load) begin
      if (xfer) begin
        y_data  <= mux_data;
        y_sel   <= gnt_idx;
        y_valid <= 1'b1;
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule
